// File: rtl/tc_pkg.sv
// Shared types for the timer output-compare stage.
// Channel mode encoding and its field width.
package tc_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    FROZEN = 2'b00,
    TOGGLE = 2'b01,
    PWM_HI = 2'b10,
    PWM_LO = 2'b11
  } tc_mode_t;

endpackage

// File: rtl/tc_compare_channel.sv
// One compare channel: preload, optional shadow, output and flag.
// TC_COMPARE_PRELOAD_EN adds the wrap-synchronised shadow register.
module tc_compare_channel
  import tc_pkg::*;
#(
  parameter int BITS_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  tc_en,
  input  logic                  tc_rst,
  input  logic                  step,
`ifdef TC_COMPARE_PRELOAD_EN
  input  logic                  reload,
`endif
  input  logic [BITS_WIDTH-1:0] tcnt,
  input  logic [BITS_WIDTH-1:0] ccr_wdata,
  input  logic                  ccr_we,
  input  logic [MODE_W-1:0]     mode,
  input  logic                  flag_clr,
  output logic                  out,
  output logic                  flag
);

  tc_mode_t              mode_e;
  logic [BITS_WIDTH-1:0] preload;
  logic [BITS_WIDTH-1:0] preload_d;
  logic [BITS_WIDTH-1:0] cmp;
  logic                  match;
  logic                  below;
  logic                  out_d;
  logic                  flag_d;

  assign mode_e    = tc_mode_t'(mode);
  assign preload_d = ccr_we ? ccr_wdata : preload;

  // Preload captures every software write.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) preload <= '0;
    else        preload <= preload_d;
  end

`ifdef TC_COMPARE_PRELOAD_EN
  logic [BITS_WIDTH-1:0] shadow;

  // Shadow follows preload while stopped, else only at wrap.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)      shadow <= '0;
    else if (reload) shadow <= preload_d;
  end

  assign cmp = shadow;
`else
  assign cmp = preload;
`endif

  // step suppresses repeat matches while the prescaler holds tcnt.
  assign match = tc_en & ~tc_rst & step & (tcnt == cmp);
  assign below = tcnt < cmp;

  // Next output and flag from mode, counter reset and match.
  always_comb begin
    out_d  = out;
    flag_d = flag;
    if (tc_rst) begin
      out_d  = (mode_e == PWM_LO);
      flag_d = 1'b0;
    end else begin
      if (tc_en) begin
        unique case (mode_e)
          FROZEN: out_d = out;
          TOGGLE: out_d = out ^ match;
          PWM_HI: out_d = below;
          PWM_LO: out_d = ~below;
        endcase
      end
      if (match)         flag_d = 1'b1;
      else if (flag_clr) flag_d = 1'b0;
    end
  end

  // Registered channel output and sticky flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out  <= 1'b0;
      flag <= 1'b0;
    end else begin
      out  <= out_d;
      flag <= flag_d;
    end
  end

endmodule

// File: rtl/tc_compare.sv
// Multi-channel output compare / PWM behind the timer time base.
// Define TC_COMPARE_PRELOAD_EN for double-buffered compare values.
module tc_compare
  import tc_pkg::*;
#(
  parameter int BITS_WIDTH = 32,
  parameter int CHANNELS   = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  tc_en,
  input  logic                  tc_rst,
  input  logic [BITS_WIDTH-1:0] tcnt,
  input  logic [BITS_WIDTH-1:0] ccr_wdata,
  input  logic [CHANNELS-1:0]   ccr_we,
  input  logic [2*CHANNELS-1:0] ch_mode,
  input  logic [CHANNELS-1:0]   ch_irq_en,
  input  logic [CHANNELS-1:0]   flag_clr,
  output logic [CHANNELS-1:0]   ch_out,
  output logic [CHANNELS-1:0]   ch_flag,
  output logic                  cc_irq
);

  logic [BITS_WIDTH-1:0] tcnt_q;
  logic                  step;

  // Previous counter value, used for wrap and step detection.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)      tcnt_q <= '0;
    else if (tc_rst) tcnt_q <= '0;
    else if (tc_en)  tcnt_q <= tcnt;
  end

  assign step = tcnt != tcnt_q;

`ifdef TC_COMPARE_PRELOAD_EN
  logic wrap;
  logic reload;

  assign wrap   = tc_en & (tcnt < tcnt_q);
  assign reload = ~tc_en | tc_rst | wrap;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    tc_compare_channel #(
      .BITS_WIDTH(BITS_WIDTH)
    ) u_ch (
      .clk      (clk),
      .n_rst    (n_rst),
      .tc_en    (tc_en),
      .tc_rst   (tc_rst),
      .step     (step),
`ifdef TC_COMPARE_PRELOAD_EN
      .reload   (reload),
`endif
      .tcnt     (tcnt),
      .ccr_wdata(ccr_wdata),
      .ccr_we   (ccr_we[i]),
      .mode     (ch_mode[MODE_W*i +: MODE_W]),
      .flag_clr (flag_clr[i]),
      .out      (ch_out[i]),
      .flag     (ch_flag[i])
    );
  end

  assign cc_irq = |(ch_flag & ch_irq_en);

endmodule

// File: doc/tc_compare.md
# tc_compare

Multi-channel output-compare / PWM stage directly downstream of the timer time base. Consumes the registered counter value `tcnt` and control bits, compares against per-channel compare registers, and drives registered channel outputs plus sticky per-channel match flags and a combined interrupt. Compare values are double-buffered and update at counter wrap-around so PWM periods never glitch.

## Interface
- `BITS_WIDTH`, 32, width of counter and compare values
- `CHANNELS`, 4, number of compare channels
- `clk` in 1: clock
- `n_rst` in 1: reset, asynchronous, active-low
- `tc_en` in 1: registered counter enable from time base
- `tc_rst` in 1: registered synchronous counter reset from time base
- `tcnt` in BITS_WIDTH: current counter value from time base
- `ccr_wdata` in BITS_WIDTH: compare value write data
- `ccr_we` in CHANNELS: per-channel compare write strobe
- `ch_mode` in 2*CHANNELS: per-channel mode, 2 bits each
- `ch_irq_en` in CHANNELS: per-channel interrupt enable
- `flag_clr` in CHANNELS: per-channel write-1-to-clear of match flag
- `ch_out` out CHANNELS: registered channel outputs
- `ch_flag` out CHANNELS: sticky match flags
- `cc_irq` out 1: OR of (`ch_flag` & `ch_irq_en`), combinational from registered state

## Operation
- Modes: 00 FROZEN (output holds), 01 TOGGLE (invert on match event), 10 PWM_HI (out = 1 while `tcnt` < shadow, else 0), 11 PWM_LO (inverse of PWM_HI).
- Internal `tcnt_q` register holds previous `tcnt`; reset 0.
- Wrap event: `tc_en`=1 and `tcnt` < `tcnt_q`.
- Match event (per channel): `tc_en`=1, `tcnt` == shadow, `tcnt` != `tcnt_q`. One event per prescaled step; no match on first enabled cycle at count 0.
- Preload register: written with `ccr_wdata` when `ccr_we[i]`=1.
- Shadow register: loads preload every cycle while `tc_en`=0 or `tc_rst`=1; while running, loads only on wrap event. Load uses preload value including a same-cycle write.
- Comparisons always use shadow value.
- Flag: set on match event; cleared by `flag_clr[i]`; set wins over simultaneous clear.
- `tc_rst`=1: flags clear, `tcnt_q` clears, FROZEN/TOGGLE outputs go 0, PWM_HI outputs 0, PWM_LO outputs 1. `tc_rst` overrides `tc_en`.
- `tc_en`=0 (no rst): outputs, flags, `tcnt_q` hold; shadow tracks preload.
- Shadow = 0 in PWM_HI: output constant 0. Shadow > counter max: output constant 1, never matches.
- Mode change takes effect on next PWM/compare evaluation; no output reset.

## Timing
- `n_rst` low: `ch_out`=0, `ch_flag`=0, `cc_irq`=0, preload/shadow/`tcnt_q`=0.
- `ch_out` and `ch_flag` update one clock after the `tcnt` value that caused them.
- Preload write to shadow: next cycle if stopped; first wrap after write if running.
- `cc_irq` follows `ch_flag`/`ch_irq_en` with zero added latency.

## Configuration
- `TC_COMPARE_PRELOAD_EN` defined: shadow buffering as above.
- Undefined: no shadow register; comparisons use preload directly, writes take effect next cycle even mid-period.

## Structure
- Package `tc_pkg`: `tc_mode_t` enum (FROZEN, TOGGLE, PWM_HI, PWM_LO), mode width constant.
- Sub-module `tc_compare_channel`: one channel (preload, shadow, output, flag); top instantiates `CHANNELS` copies via generate, owns `tcnt_q`, wrap/step detection, `cc_irq` OR.

## Test plan
- PWM_HI, ccr=3, counter 0..9 wrapping, tc_en=1 -> `ch_out` high for counts 0,1,2, low 3..9, each one cycle delayed; flag sets once per period.
- Running PWM_HI ccr=3, write ccr=7 mid-period at tcnt=5 -> duty stays 3 until wrap, then 7 (preload on); without macro duty changes next cycle.
- TOGGLE ccr=0, counter 0..4 with prescaler 2 -> `ch_out` toggles once per period at wrap to 0, not on held cycles.
- flag_clr and match in same cycle -> flag stays 1; `ch_irq_en`=1 -> `cc_irq`=1; clear alone -> 0.
- tc_rst mid-period with PWM_LO -> `ch_out`=1, flags 0 next cycle; shadow loads preload while held.
- n_rst asserted mid-operation -> all outputs 0 asynchronously; restart matches from 0.
